// File: rtl/msg_pkg.sv
// msg_pkg: shared constants and types for the cluster message unpacker.
package msg_pkg;
   localparam int CLUSTER_BYTES = 4;
   localparam int CHAR_W = 8;
   localparam logic [CHAR_W-1:0] NUL_CHAR = 8'h00;
   typedef logic [1:0] byte_idx_t;
   typedef logic [CLUSTER_BYTES-1:0][CHAR_W-1:0] cluster_t;
   localparam logic [1:0] B0 = 2'd0;
   localparam logic [1:0] B3 = 2'd3;
endpackage

// File: rtl/msg_cluster_fifo.sv
// msg_cluster_fifo: synchronous cluster FIFO with count-based full/empty, no bypass.
module msg_cluster_fifo
   import msg_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  cluster_t wdata,
   input  logic     pop,
   output logic     full,
   output logic     empty,
   output cluster_t head
);
   localparam int AW = $clog2(DEPTH);
   cluster_t mem_q [DEPTH];
   cluster_t mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic wen, ren;
   always_comb begin
      full = cnt_q == (AW+1)'(DEPTH);
      empty = cnt_q == '0;
      wen = push && !full;
      ren = pop && !empty;
      mem_d = mem_q;
      if (wen) mem_d[wr_q] = wdata;
      wr_d = wr_q + AW'(wen);
      rd_d = rd_q + AW'(ren);
      cnt_d = cnt_q + (AW+1)'(wen) - (AW+1)'(ren);
      head = mem_q[rd_q];
   end
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/msg_unpacker.sv
// msg_unpacker: drops failed clusters, buffers good ones and streams them bytewise.
// Define MSG_ERR_CNT_EN to add the saturating err_count output and its ERR_W parameter.
module msg_unpacker
   import msg_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
`ifdef MSG_ERR_CNT_EN
   , parameter int ERR_W = 8
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CHAR_W-1:0] cluster_data0,
   input  logic [CHAR_W-1:0] cluster_data1,
   input  logic [CHAR_W-1:0] cluster_data2,
   input  logic [CHAR_W-1:0] cluster_data3,
   input  logic              csum_ok,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CHAR_W-1:0] out_char,
   output logic              out_last,
   output logic              drop_pulse
`ifdef MSG_ERR_CNT_EN
   , output logic [ERR_W-1:0] err_count
`endif
);
   logic full, empty, accept, push, pop, hs, drop_q, drop_d;
   cluster_t head;
   byte_idx_t idx_q, idx_d;
   msg_cluster_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({cluster_data3, cluster_data2, cluster_data1, cluster_data0}),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head)
   );
   // A NUL ends the message early; the rest of its cluster is padding and is popped with it.
   always_comb begin
      in_ready = rst_n && !full;
      accept = in_valid && in_ready;
      push = accept && csum_ok;
      drop_d = accept && !csum_ok;
      out_valid = !empty;
      out_char = empty ? NUL_CHAR : head[idx_q];
      out_last = out_valid && out_char == NUL_CHAR;
      hs = out_valid && out_ready;
      pop = hs && (out_last || idx_q == B3);
      idx_d = pop ? B0 : hs ? idx_q + 2'd1 : idx_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q <= B0;
         drop_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         drop_q <= drop_d;
      end
   end
   assign drop_pulse = drop_q;
`ifdef MSG_ERR_CNT_EN
   logic [ERR_W-1:0] err_q, err_d;
   always_comb err_d = (drop_d && err_q != '1) ? err_q + ERR_W'(1) : err_q;
   always_ff @(posedge clk) begin
      if (!rst_n) err_q <= '0;
      else err_q <= err_d;
   end
   assign err_count = err_q;
`endif
endmodule
